cache_fill_ctrl: RTL and testbench

//  Requester side of the 4-cycle pipelined read / single-cycle write memory.
//  - On a cache miss, fetches one 8-word (16-byte) block: one read request per cycle, no stalls.
//  - Streams each returned word into the cache data array, then writes the tag array.
//  - Also forwards single-cycle write-through stores while idle.
//  - Sits between the I/D cache control logic and the memory.

---
 rtl/cache_fill_ctrl.sv | 146 ++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// Cache block fill controller for the 4-cycle pipelined read / 1-cycle write memory.
// Optional fill watchdog built when CACHE_FILL_TIMEOUT_EN is defined.
module cache_fill_ctrl #(
   parameter int ADDR_WIDTH      = 16,
   parameter int WORDS_PER_BLOCK = 8,
   parameter int TIMEOUT_CYCLES  = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               miss_detected,
   input  logic [ADDR_WIDTH-1:0]              miss_address,
   input  logic                               store_req,
   input  logic [ADDR_WIDTH-1:0]              store_addr,
   input  logic [15:0]                        store_data,
   output logic                               store_ack,
   output logic                               fsm_busy,
   output logic                               mem_enable,
   output logic                               mem_wr,
   output logic [ADDR_WIDTH-1:0]              mem_addr,
   output logic [15:0]                        mem_data_out,
   input  logic [15:0]                        mem_data_in,
   input  logic                               mem_data_valid,
   output logic                               write_data_array,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_index,
   output logic [15:0]                        fill_data,
   output logic                               write_tag_array,
   output logic                               fill_done,
   output logic                               fill_error
);

   localparam int AW = ADDR_WIDTH;
   localparam int IW = $clog2(WORDS_PER_BLOCK);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_PER_BLOCK - 1);
   localparam logic [AW-1:0] BLK_MASK = AW'(2 * WORDS_PER_BLOCK - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } state_t;

   state_t        state;
   logic [AW-1:0] base;
   logic [IW-1:0] req_cnt;
   logic [IW-1:0] rsp_cnt;

   logic          in_fill;
   logic          rsp;
   logic          last_rsp;
   logic          store_go;
   logic          timeout;
   logic [AW-1:0] req_addr;

   assign in_fill  = (state == REQ) || (state == WAIT);
   assign rsp      = in_fill && mem_data_valid;
   assign last_rsp = rsp && (rsp_cnt == LAST_IDX);
   assign store_go = (state == IDLE) && store_req;
   // base is block aligned, so the word offset never carries out of the block
   assign req_addr = base | AW'({req_cnt, 1'b0});

`ifdef CACHE_FILL_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [WW-1:0] wd_cnt;

   assign timeout = in_fill && !mem_data_valid &&
                    (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (!in_fill || mem_data_valid) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign fill_error = timeout;
`else
   assign timeout    = 1'b0;
   assign fill_error = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         base    <= '0;
         req_cnt <= '0;
         rsp_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!store_req && miss_detected) begin
                  base    <= miss_address & ~BLK_MASK;
                  req_cnt <= '0;
                  rsp_cnt <= '0;
                  state   <= REQ;
               end
            end
            REQ: begin
               req_cnt <= req_cnt + 1'b1;
               if (req_cnt == LAST_IDX) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               state <= WAIT;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (rsp) begin
            rsp_cnt <= rsp_cnt + 1'b1;
         end
         if (last_rsp) begin
            state <= DONE;
         end
         if (timeout) begin
            state <= IDLE;
         end
      end
   end

   assign fsm_busy  = (state != IDLE);
   assign fill_done = (state == DONE);
   assign store_ack = store_go;

   assign mem_enable   = store_go || (state == REQ);
   assign mem_wr       = store_go;
   assign mem_addr     = store_go       ? store_addr :
                         (state == REQ) ? req_addr   : '0;
   assign mem_data_out = store_go ? store_data : '0;

   assign write_data_array = rsp;
   assign word_index       = rsp ? rsp_cnt : '0;
   assign fill_data        = rsp ? mem_data_in : '0;
   assign write_tag_array  = last_rsp;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a pipelined memory model and
// request/word scoreboards.
module tb_cache_fill_ctrl;

   logic        clk;
   logic        rst_n;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        store_req;
   logic [15:0] store_addr;
   logic [15:0] store_data;
   logic        store_ack;
   logic        fsm_busy;
   logic        mem_enable;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_out;
   logic [15:0] mem_data_in;
   logic        mem_data_valid;
   logic        write_data_array;
   logic [2:0]  word_index;
   logic [15:0] fill_data;
   logic        write_tag_array;
   logic        fill_done;
   logic        fill_error;

   cache_fill_ctrl #(
      .ADDR_WIDTH      (16),
      .WORDS_PER_BLOCK (8),
      .TIMEOUT_CYCLES  (32)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .miss_detected    (miss_detected),
      .miss_address     (miss_address),
      .store_req        (store_req),
      .store_addr       (store_addr),
      .store_data       (store_data),
      .store_ack        (store_ack),
      .fsm_busy         (fsm_busy),
      .mem_enable       (mem_enable),
      .mem_wr           (mem_wr),
      .mem_addr         (mem_addr),
      .mem_data_out     (mem_data_out),
      .mem_data_in      (mem_data_in),
      .mem_data_valid   (mem_data_valid),
      .write_data_array (write_data_array),
      .word_index       (word_index),
      .fill_data        (fill_data),
      .write_tag_array  (write_tag_array),
      .fill_done        (fill_done),
      .fill_error       (fill_error)
   );

   typedef struct packed {
      logic [2:0]  idx;
      logic [15:0] data;
   } wexp_t;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_req[$];
   wexp_t       exp_word[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: contents before any store
   function automatic logic [15:0] ref_init(input logic [15:0] a);
      if (a >= 16'h1230 && a <= 16'h123E) return 16'hA000 + 16'((a - 16'h1230) >> 1);
      return a ^ 16'h5A5A;
   endfunction

   logic [15:0] mem [0:32767];
   bit          wv  [0:32767];
   logic [2:0]  pv = '0;
   logic [15:0] pa [0:2];
   logic        mv = 1'b0;
   logic [15:0] md = '0;
   bit          supp = 1'b0;

   always @(posedge clk) begin
      if (mem_enable && mem_wr) begin
         mem[mem_addr[15:1]] <= mem_data_out;
         wv[mem_addr[15:1]]  <= 1'b1;
      end
      pv    <= {pv[1:0], mem_enable && !mem_wr};
      pa[0] <= mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      mv    <= pv[2];
      md    <= wv[pa[2][15:1]] ? mem[pa[2][15:1]] : ref_init(pa[2]);
   end

   assign mem_data_valid = mv && !supp;
   assign mem_data_in    = md;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // scoreboard side: every request and every array write is popped and compared
   always @(negedge clk) begin
      if (rst_n && mem_enable && !mem_wr) begin
         check("req_pending", 32'(exp_req.size() > 0), 32'd1);
         if (exp_req.size() > 0) check("req_addr", 32'(mem_addr), 32'(exp_req.pop_front()));
      end
      if (rst_n && write_data_array) begin
         check("word_pending", 32'(exp_word.size() > 0), 32'd1);
         if (exp_word.size() > 0) begin
            wexp_t e;
            e = exp_word.pop_front();
            check("word_idx", 32'(word_index), 32'(e.idx));
            check("word_data", 32'(fill_data), 32'(e.data));
            check("tag_flag", 32'(write_tag_array), 32'(e.idx == 3'd7));
         end
      end
      if (write_tag_array) check("tag_with_word", 32'(write_data_array), 32'd1);
   end

   task automatic push_block(input logic [15:0] a, input bit ov_en,
                             input logic [2:0] ov_idx, input logic [15:0] ov_val);
      logic [15:0] b;
      logic [15:0] wa;
      b = a & 16'hFFF0;
      for (int k = 0; k < 8; k++) begin
         wa = b + 16'(2 * k);
         exp_req.push_back(wa);
         exp_word.push_back({3'(k), (ov_en && ov_idx == 3'(k)) ? ov_val : ref_init(wa)});
      end
   endtask

   task automatic do_fill(input string tag, input logic [15:0] a, input int lat,
                          input bit st_en, input logic [15:0] st_a, input logic [15:0] st_d,
                          input bit ov_en, input logic [2:0] ov_idx, input logic [15:0] ov_val);
      int first_r = -1;
      int first_w = -1;
      int tag_c   = -1;
      int done_c  = -1;
      int err_n   = 0;
      push_block(a, ov_en, ov_idx, ov_val);
      for (int c = 0; c < 40 && done_c < 0; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            miss_detected = 1'b1;
            miss_address  = a;
            if (st_en) begin
               store_req  = 1'b1;
               store_addr = st_a;
               store_data = st_d;
            end
         end
         if (c == 1) store_req = 1'b0;
         @(negedge clk);
         if (c == 0 && st_en) begin
            check({tag, "_st_ack"}, 32'(store_ack), 32'd1);
            check({tag, "_st_addr"}, 32'(mem_addr), 32'(st_a));
            check({tag, "_st_wr"}, 32'({mem_enable, mem_wr}), 32'd3);
         end
         if (mem_enable && !mem_wr && first_r < 0) first_r = c;
         if (write_data_array && first_w < 0) first_w = c;
         if (write_tag_array) tag_c = c;
         if (fill_error) err_n++;
         if (fill_done) done_c = c;
      end
      check({tag, "_first_req"}, 32'(first_r), 32'(1 + lat));
      check({tag, "_first_word"}, 32'(first_w), 32'(5 + lat));
      check({tag, "_tag_cyc"}, 32'(tag_c), 32'(12 + lat));
      check({tag, "_done_cyc"}, 32'(done_c), 32'(13 + lat));
      check({tag, "_no_err"}, 32'(err_n), 32'd0);
      @(posedge clk);
      #1;
      miss_detected = 1'b0;
      @(negedge clk);
      check({tag, "_idle"}, 32'(fsm_busy), 32'd0);
      check({tag, "_req_q"}, 32'(exp_req.size()), 32'd0);
      check({tag, "_word_q"}, 32'(exp_word.size()), 32'd0);
      exp_req.delete();
      exp_word.delete();
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctrl"}, 32'({fsm_busy, mem_enable, mem_wr, store_ack, write_data_array,
                                 write_tag_array, fill_done, fill_error}), 32'd0);
      check({tag, "_bus"}, 32'(mem_addr | mem_data_out | fill_data | 16'(word_index)), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed running expected finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int stale;
      rst_n         = 1'b0;
      miss_detected = 1'b0;
      miss_address  = '0;
      store_req     = 1'b0;
      store_addr    = '0;
      store_data    = '0;
      #2;
      check_quiet("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_fill("fill", 16'h1236, 0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);

      @(posedge clk);
      #1;
      store_req  = 1'b1;
      store_addr = 16'h0040;
      store_data = 16'hBEEF;
      @(negedge clk);
      check("store_ack", 32'(store_ack), 32'd1);
      check("store_wr", 32'({mem_enable, mem_wr}), 32'd3);
      check("store_addr", 32'(mem_addr), 32'h0040);
      check("store_data", 32'(mem_data_out), 32'hBEEF);
      check("store_busy", 32'(fsm_busy), 32'd0);
      @(posedge clk);
      #1;
      store_req = 1'b0;
      @(negedge clk);
      check("store_ack_off", 32'(store_ack), 32'd0);
      do_fill("st_fill", 16'h0040, 0, 1'b0, 16'h0, 16'h0, 1'b1, 3'd0, 16'hBEEF);

      do_fill("collide", 16'h3000, 1, 1'b1, 16'h3002, 16'h1357, 1'b1, 3'd1, 16'h1357);

      do_fill("wrap", 16'hFFFE, 0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);

      push_block(16'h0800, 1'b0, 3'd0, 16'h0);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            miss_detected = 1'b1;
            miss_address  = 16'h0800;
         end
         @(negedge clk);
      end
      check("mid_req_en", 32'(mem_enable), 32'd1);
      check("mid_req_addr", 32'(mem_addr), 32'h0804);
      rst_n = 1'b0;
      #1;
      check_quiet("async_rst");
      exp_req.delete();
      exp_word.delete();
      miss_detected = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      for (int c = 5; c < 12; c++) begin
         @(negedge clk);
         if (mem_data_valid) begin
            stale++;
            check("stale_no_write", 32'(write_data_array), 32'd0);
         end
         check("stale_idle", 32'(fsm_busy), 32'd0);
      end
      check("stale_seen", 32'(stale), 32'd2);

      do_fill("refill", 16'h1230, 0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);

`ifdef CACHE_FILL_TIMEOUT_EN
      begin
         int err_c = -1;
         int tag_n = 0;
         push_block(16'h1236, 1'b0, 3'd0, 16'h0);
         for (int c = 0; c < 60 && err_c < 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
               miss_detected = 1'b1;
               miss_address  = 16'h1236;
            end
            if (c == 8) supp = 1'b1;
            @(negedge clk);
            if (write_tag_array) tag_n++;
            if (fill_error) err_c = c;
         end
         check("to_err_cyc", 32'(err_c), 32'd39);
         check("to_no_tag", 32'(tag_n), 32'd0);
         check("to_words_left", 32'(exp_word.size()), 32'd5);
         @(posedge clk);
         #1;
         miss_detected = 1'b0;
         supp          = 1'b0;
         @(negedge clk);
         check("to_idle", 32'(fsm_busy), 32'd0);
         check("to_err_pulse", 32'(fill_error), 32'd0);
         exp_req.delete();
         exp_word.delete();
      end
`endif

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
